bitty_sequencer: RTL
====================

# bitty_sequencer

Program sequencer for the bitty core: fetches 16-bit instructions from a synchronous instruction memory, resolves branches locally, and dispatches every other instruction to bitty over the run/d_instr/done handshake. It owns the program counter, so bitty needs no fetch logic. It sits between the instruction ROM/RAM and the bitty datapath, and exposes start/stop control plus status to the top level.

## Interface
- ADDR_W, 8, instruction memory address width and PC width; legal range 1..12.
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; begins execution at address 0 when idle.
- stop  input  1  level; finish current instruction, then go idle.
- imem_en  output  1  memory read strobe.
- imem_addr  output  ADDR_W  memory read address.
- imem_data  input  16  read data, valid exactly 1 cycle after imem_en.
- run  output  1  to bitty; execute d_instr.
- d_instr  output  16  to bitty; instruction word.
- done  input  1  from bitty; instruction complete.
- d_out  input  16  from bitty; last ALU result, used for branch conditions.
- busy  output  1  high in every state except IDLE and HALTED.
- halted  output  1  high after a HALT word is fetched, until the next start or reset.
- pc  output  ADDR_W  current program counter.
- retired  output  16  count of dispatched instructions that completed.

## Operation
- States: IDLE, FETCH, LATCH, DISPATCH, EXEC, HALTED (+BREAK, see Configuration).
- IDLE: wait for start; on start, pc<=0, retired<=0, halted<=0 -> FETCH.
- FETCH: imem_en=1, imem_addr=pc -> LATCH.
- LATCH: ir<=imem_data -> DISPATCH.
- DISPATCH decode, in priority order:
  - ir==16'h0000 (HALT): halted<=1 -> HALTED; nothing is dispatched.
  - ir[1:0]==2'b10 (branch): taken when d_out=={14'b0, ir[3:2]}. If taken, pc<=ir[ADDR_W+3:4]; otherwise pc<=pc+1. Next state FETCH; nothing is dispatched and retired does not increment.
  - Any other instruction: d_instr<=ir, run<=1 -> EXEC.
- EXEC: hold run=1 and d_instr stable until done=1 is sampled. On that edge: run<=0, pc<=pc+1, retired<=retired+1. Then go to IDLE if stop=1, otherwise FETCH.
- HALTED: wait for start; on start, restart from address 0 as in IDLE.
- stop observed in FETCH/LATCH/DISPATCH: the instruction in flight completes, including its EXEC if it is dispatched; stop is checked only at the EXEC exit and at the exit of a branch DISPATCH.
- start ignored while busy=1. Start and stop high in the same cycle in IDLE: start wins; stop is honoured at the first check point.
- pc+1 wraps modulo 2^ADDR_W. retired wraps modulo 2^16.
- Branch target bits above ADDR_W are ignored.

## Timing
- Reset values: run=0, d_instr=0, imem_en=0, imem_addr=0, pc=0, busy=0, halted=0, retired=0, state IDLE.
- All outputs are registered except imem_en/imem_addr, which decode from state and pc combinationally.
- start pulse at cycle N -> imem_en at N+1 -> ir loaded at N+3 -> run high from N+4.
- Dispatched instruction overhead: 3 cycles (FETCH, LATCH, DISPATCH) plus bitty latency. A branch costs 3 cycles.
- done is sampled only in EXEC. A done pulse in any other state is ignored.
- Reset asserted mid-operation: all state and outputs return to reset values on that edge; run drops immediately. bitty is reset by the same signal.

## Configuration
- BITTY_SEQ_BREAKPOINT_EN defined:
  - Adds inputs bp_en (1), bp_addr (ADDR_W), resume (1), and output at_bp (1).
  - Entering FETCH with bp_en=1 and pc==bp_addr goes to BREAK instead (at_bp=1, busy=1, no imem_en).
  - A resume pulse fetches at pc and skips the breakpoint check for that single fetch.
  - stop in BREAK -> IDLE.
- BITTY_SEQ_BREAKPOINT_EN undefined: these ports, the BREAK state and the comparator are absent; behaviour is otherwise identical.

## Structure
- bitty_pkg holds:
  - format codes (FMT_BRANCH=2'b10);
  - HALT_WORD=16'h0000;
  - the sequencer state enum;
  - branch condition codes (EQ=0, GT=1, LT=2).
- One sub-module: branch_resolver (combinational). Inputs ir, d_out, pc; outputs is_branch, taken, next_pc.

## Test plan
- Program {imm op, reg op, HALT}; bitty done 2 cycles after run -> 2 run pulses, retired=2, halted=1, pc=2, busy=0.
- Branch at address 1 with ir[3:2]=0, target 5, d_out=0 -> next imem_addr=5, no run for that word, retired unchanged; repeat with d_out=1 -> imem_addr=2.
- ADDR_W=4, pc=15 executing a non-branch -> next fetch at address 0.
- stop raised while run high, done 3 cycles later -> retired increments once, state IDLE, no further imem_en.
- reset pulsed during EXEC -> next cycle run=0, pc=0, retired=0, busy=0; a later start restarts at address 0.
- With BITTY_SEQ_BREAKPOINT_EN: bp_en=1, bp_addr=3 -> at_bp=1 with pc=3 and no imem_en; resume -> fetch of address 3 and execution continues.

Source files
------------

// File: rtl/bitty_pkg.sv
// Shared definitions for the bitty sequencer: instruction format codes, HALT word, FSM states.
// Defining BITTY_SEQ_BREAKPOINT_EN adds the BREAK state used by the optional breakpoint logic.
package bitty_pkg;

    localparam logic [1:0]  FMT_BRANCH = 2'b10;
    localparam logic [15:0] HALT_WORD  = 16'h0000;

    typedef enum logic [1:0] {
        COND_EQ = 2'd0,
        COND_GT = 2'd1,
        COND_LT = 2'd2
    } branch_cond_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LATCH,
        ST_DISPATCH,
        ST_EXEC,
        ST_HALTED
`ifdef BITTY_SEQ_BREAKPOINT_EN
        , ST_BREAK
`endif
    } seq_state_t;

endpackage

// File: rtl/bitty_sequencer_branch_resolver.sv
// Combinational branch decode: a branch is taken when the last ALU result equals the 2-bit
// condition field; target bits above the PC width are dropped.
module branch_resolver
    import bitty_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic [15:0]       ir,
    input  logic [15:0]       d_out,
    input  logic [ADDR_W-1:0] pc,
    output logic              is_branch,
    output logic              taken,
    output logic [ADDR_W-1:0] next_pc
);

    localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

    assign is_branch = (ir != HALT_WORD) && (ir[1:0] == FMT_BRANCH);
    assign taken     = is_branch && (d_out == {14'b0, ir[3:2]});
    assign next_pc   = taken ? ir[ADDR_W+3:4] : pc + PC_ONE;

endmodule

// File: rtl/bitty_sequencer.sv
// Program sequencer for bitty: fetches from a synchronous imem, resolves branches locally and
// dispatches other words over run/done. BITTY_SEQ_BREAKPOINT_EN adds breakpoint ports and state.
module bitty_sequencer
    import bitty_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    output logic              imem_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [15:0]       imem_data,
    output logic              run,
    output logic [15:0]       d_instr,
    input  logic              done,
    input  logic [15:0]       d_out,
    output logic              busy,
    output logic              halted,
    output logic [ADDR_W-1:0] pc,
    output logic [15:0]       retired
`ifdef BITTY_SEQ_BREAKPOINT_EN
    ,
    input  logic              bp_en,
    input  logic [ADDR_W-1:0] bp_addr,
    input  logic              resume,
    output logic              at_bp
`endif
);

    localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

    seq_state_t        state_reg, state_next;
    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic [15:0]       retired_reg, retired_next;
    logic              halted_reg, halted_next;
    logic              run_reg, run_next;
    logic [15:0]       d_instr_reg, d_instr_next;
    logic [15:0]       ir_reg, ir_next;
    logic              busy_reg;

    logic              br_is_branch;
    logic              br_taken;
    logic [ADDR_W-1:0] br_next_pc;
    logic [ADDR_W-1:0] pc_inc;

`ifdef BITTY_SEQ_BREAKPOINT_EN
    logic              skip_bp;
    logic              at_bp_reg;
`endif

    branch_resolver #(
        .ADDR_W(ADDR_W)
    ) u_branch_resolver (
        .ir       (ir_reg),
        .d_out    (d_out),
        .pc       (pc_reg),
        .is_branch(br_is_branch),
        .taken    (br_taken),
        .next_pc  (br_next_pc)
    );

    assign pc_inc = pc_reg + PC_ONE;

    always_comb begin
        state_next   = state_reg;
        pc_next      = pc_reg;
        retired_next = retired_reg;
        halted_next  = halted_reg;
        run_next     = run_reg;
        d_instr_next = d_instr_reg;
        ir_next      = ir_reg;
`ifdef BITTY_SEQ_BREAKPOINT_EN
        skip_bp      = 1'b0;
`endif
        case (state_reg)
            ST_IDLE, ST_HALTED: begin
                if (start) begin
                    pc_next      = '0;
                    retired_next = '0;
                    halted_next  = 1'b0;
                    state_next   = ST_FETCH;
                end
            end
            ST_FETCH: state_next = ST_LATCH;
            ST_LATCH: begin
                ir_next    = imem_data;
                state_next = ST_DISPATCH;
            end
            ST_DISPATCH: begin
                if (ir_reg == HALT_WORD) begin
                    halted_next = 1'b1;
                    state_next  = ST_HALTED;
                end else if (br_is_branch) begin
                    pc_next    = br_taken ? br_next_pc : pc_inc;
                    state_next = stop ? ST_IDLE : ST_FETCH;
                end else begin
                    d_instr_next = ir_reg;
                    run_next     = 1'b1;
                    state_next   = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (done) begin
                    run_next     = 1'b0;
                    pc_next      = pc_inc;
                    retired_next = retired_reg + 16'd1;
                    state_next   = stop ? ST_IDLE : ST_FETCH;
                end
            end
`ifdef BITTY_SEQ_BREAKPOINT_EN
            ST_BREAK: begin
                if (stop) begin
                    state_next = ST_IDLE;
                end else if (resume) begin
                    skip_bp    = 1'b1;
                    state_next = ST_FETCH;
                end
            end
`endif
            default: state_next = ST_IDLE;
        endcase
`ifdef BITTY_SEQ_BREAKPOINT_EN
        // Every route into FETCH passes through here, so one comparator covers them all.
        if (state_next == ST_FETCH && !skip_bp && bp_en && pc_next == bp_addr) begin
            state_next = ST_BREAK;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            pc_reg      <= '0;
            retired_reg <= '0;
            halted_reg  <= 1'b0;
            run_reg     <= 1'b0;
            d_instr_reg <= '0;
            ir_reg      <= '0;
            busy_reg    <= 1'b0;
`ifdef BITTY_SEQ_BREAKPOINT_EN
            at_bp_reg   <= 1'b0;
`endif
        end else begin
            state_reg   <= state_next;
            pc_reg      <= pc_next;
            retired_reg <= retired_next;
            halted_reg  <= halted_next;
            run_reg     <= run_next;
            d_instr_reg <= d_instr_next;
            ir_reg      <= ir_next;
            busy_reg    <= (state_next != ST_IDLE) && (state_next != ST_HALTED);
`ifdef BITTY_SEQ_BREAKPOINT_EN
            at_bp_reg   <= (state_next == ST_BREAK);
`endif
        end
    end

    assign imem_en   = (state_reg == ST_FETCH);
    assign imem_addr = pc_reg;
    assign run       = run_reg;
    assign d_instr   = d_instr_reg;
    assign busy      = busy_reg;
    assign halted    = halted_reg;
    assign pc        = pc_reg;
    assign retired   = retired_reg;
`ifdef BITTY_SEQ_BREAKPOINT_EN
    assign at_bp     = at_bp_reg;
`endif

endmodule
